// File: rtl/proc6_control_unit.sv
// FSM controller for the 6-instruction processor: owns PC and IR and sequences
// fetch/decode/execute. Datapath controls come straight from registers, so reset clears them at once.
module proc6_control_unit #(
   parameter int unsigned PC_WIDTH      = 16,
   parameter int unsigned D_ADDR_WIDTH  = 8,
   parameter int unsigned RF_ADDR_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [PC_WIDTH-1:0]      i_addr,
   output logic                     i_rd,
   input  logic [15:0]              i_data,
   output logic [D_ADDR_WIDTH-1:0]  d_addr,
   output logic                     d_rd,
   output logic                     d_wr,
   output logic [7:0]               rf_w_data,
   output logic [1:0]               rf_s,
   output logic [RF_ADDR_WIDTH-1:0] rf_w_addr,
   output logic                     rf_w_wr,
   output logic [RF_ADDR_WIDTH-1:0] rf_rp_addr,
   output logic                     rf_rp_rd,
   output logic [RF_ADDR_WIDTH-1:0] rf_rq_addr,
   output logic                     rf_rq_rd,
   input  logic                     rf_rp_zero,
   output logic [1:0]               alu_s,
   output logic [3:0]               state_dbg
);

   typedef enum logic [3:0] {
      StInit   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StLoad   = 4'd3,
      StStore  = 4'd4,
      StAdd    = 4'd5,
      StLoadc  = 4'd6,
      StSub    = 4'd7,
      StJmpz   = 4'd8,
      StJmpzT  = 4'd9
   } state_e;

   state_e                   r_state;
   logic [PC_WIDTH-1:0]      r_pc;
   logic [15:0]              r_ir;

   logic                     r_i_rd;
   logic [D_ADDR_WIDTH-1:0]  r_d_addr;
   logic                     r_d_rd;
   logic                     r_d_wr;
   logic [7:0]               r_rf_w_data;
   logic [1:0]               r_rf_s;
   logic [RF_ADDR_WIDTH-1:0] r_rf_w_addr;
   logic                     r_rf_w_wr;
   logic [RF_ADDR_WIDTH-1:0] r_rf_rp_addr;
   logic                     r_rf_rp_rd;
   logic [RF_ADDR_WIDTH-1:0] r_rf_rq_addr;
   logic                     r_rf_rq_rd;
   logic [1:0]               r_alu_s;

   logic [3:0]               w_op;
   logic [RF_ADDR_WIDTH-1:0] w_ra;
   logic [RF_ADDR_WIDTH-1:0] w_rb;
   logic [RF_ADDR_WIDTH-1:0] w_rc;
   logic [D_ADDR_WIDTH-1:0]  w_d;
   logic [PC_WIDTH-1:0]      w_offset;

   assign w_op     = r_ir[15:12];
   assign w_ra     = r_ir[8 +: RF_ADDR_WIDTH];
   assign w_rb     = r_ir[4 +: RF_ADDR_WIDTH];
   assign w_rc     = r_ir[0 +: RF_ADDR_WIDTH];
   assign w_d      = r_ir[D_ADDR_WIDTH-1:0];
   assign w_offset = {{(PC_WIDTH-8){r_ir[7]}}, r_ir[7:0]};

   // Outputs are loaded together with the state they belong to, i.e. on the
   // edge that enters that state, so every output is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StInit;
         r_pc         <= '0;
         r_ir         <= '0;
         r_i_rd       <= 1'b0;
         r_d_addr     <= '0;
         r_d_rd       <= 1'b0;
         r_d_wr       <= 1'b0;
         r_rf_w_data  <= '0;
         r_rf_s       <= '0;
         r_rf_w_addr  <= '0;
         r_rf_w_wr    <= 1'b0;
         r_rf_rp_addr <= '0;
         r_rf_rp_rd   <= 1'b0;
         r_rf_rq_addr <= '0;
         r_rf_rq_rd   <= 1'b0;
         r_alu_s      <= '0;
      end else begin
         r_i_rd       <= 1'b0;
         r_d_addr     <= '0;
         r_d_rd       <= 1'b0;
         r_d_wr       <= 1'b0;
         r_rf_w_data  <= '0;
         r_rf_s       <= '0;
         r_rf_w_addr  <= '0;
         r_rf_w_wr    <= 1'b0;
         r_rf_rp_addr <= '0;
         r_rf_rp_rd   <= 1'b0;
         r_rf_rq_addr <= '0;
         r_rf_rq_rd   <= 1'b0;
         r_alu_s      <= '0;
         unique case (r_state)
            StInit: begin
               r_state <= StFetch;
               r_i_rd  <= 1'b1;
            end
            StFetch: begin
               r_ir    <= i_data;
               r_pc    <= r_pc + PC_WIDTH'(1);
               r_state <= StDecode;
            end
            StDecode: begin
               case (w_op)
                  4'h0: begin
                     r_state     <= StLoad;
                     r_d_addr    <= w_d;
                     r_d_rd      <= 1'b1;
                     r_rf_s      <= 2'b01;
                     r_rf_w_addr <= w_ra;
                     r_rf_w_wr   <= 1'b1;
                  end
                  4'h1: begin
                     r_state      <= StStore;
                     r_d_addr     <= w_d;
                     r_d_wr       <= 1'b1;
                     r_rf_rp_addr <= w_ra;
                     r_rf_rp_rd   <= 1'b1;
                  end
                  4'h2, 4'h4: begin
                     r_state      <= (w_op == 4'h2) ? StAdd : StSub;
                     r_alu_s      <= (w_op == 4'h2) ? 2'b01 : 2'b10;
                     r_rf_rp_addr <= w_rb;
                     r_rf_rp_rd   <= 1'b1;
                     r_rf_rq_addr <= w_rc;
                     r_rf_rq_rd   <= 1'b1;
                     r_rf_w_addr  <= w_ra;
                     r_rf_w_wr    <= 1'b1;
                  end
                  4'h3: begin
                     r_state     <= StLoadc;
                     r_rf_s      <= 2'b10;
                     r_rf_w_data <= r_ir[7:0];
                     r_rf_w_addr <= w_ra;
                     r_rf_w_wr   <= 1'b1;
                  end
                  4'h5: begin
                     r_state      <= StJmpz;
                     r_rf_rp_addr <= w_ra;
                     r_rf_rp_rd   <= 1'b1;
                  end
                  default: begin
                     r_state <= StFetch;
                     r_i_rd  <= 1'b1;
                  end
               endcase
            end
            StLoad, StStore, StAdd, StLoadc, StSub: begin
               r_state <= StFetch;
               r_i_rd  <= 1'b1;
            end
            StJmpz: begin
               if (rf_rp_zero) begin
                  r_state <= StJmpzT;
               end else begin
                  r_state <= StFetch;
                  r_i_rd  <= 1'b1;
               end
            end
            StJmpzT: begin
               // PC already points past the JMPZ; the offset is relative to the JMPZ itself.
               r_pc    <= r_pc + w_offset - PC_WIDTH'(1);
               r_state <= StFetch;
               r_i_rd  <= 1'b1;
            end
            default: r_state <= StInit;
         endcase
      end
   end

   assign i_addr     = r_pc;
   assign i_rd       = r_i_rd;
   assign d_addr     = r_d_addr;
   assign d_rd       = r_d_rd;
   assign d_wr       = r_d_wr;
   assign rf_w_data  = r_rf_w_data;
   assign rf_s       = r_rf_s;
   assign rf_w_addr  = r_rf_w_addr;
   assign rf_w_wr    = r_rf_w_wr;
   assign rf_rp_addr = r_rf_rp_addr;
   assign rf_rp_rd   = r_rf_rp_rd;
   assign rf_rq_addr = r_rf_rq_addr;
   assign rf_rq_rd   = r_rf_rq_rd;
   assign alu_s      = r_alu_s;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_proc6_control_unit.sv
// Scoreboard bench for proc6_control_unit: a program-flow model pushes the expected per-cycle
// output snapshot for each instruction; the drain loop pops and compares one per cycle.
module tb_proc6_control_unit;

   localparam logic [3:0] S_INIT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_LOAD   = 4'd3;
   localparam logic [3:0] S_STORE  = 4'd4;
   localparam logic [3:0] S_ADD    = 4'd5;
   localparam logic [3:0] S_LOADC  = 4'd6;
   localparam logic [3:0] S_SUB    = 4'd7;
   localparam logic [3:0] S_JMPZ   = 4'd8;
   localparam logic [3:0] S_JMPZT  = 4'd9;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] ia;
      logic        ird;
      logic [7:0]  da;
      logic        drd;
      logic        dwr;
      logic [7:0]  wd;
      logic [1:0]  rs;
      logic [3:0]  wa;
      logic        wwr;
      logic [3:0]  pa;
      logic        prd;
      logic [3:0]  qa;
      logic        qrd;
      logic [1:0]  alu;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  v;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] i_addr;
   logic        i_rd;
   logic [15:0] i_data;
   logic [7:0]  d_addr;
   logic        d_rd;
   logic        d_wr;
   logic [7:0]  rf_w_data;
   logic [1:0]  rf_s;
   logic [3:0]  rf_w_addr;
   logic        rf_w_wr;
   logic [3:0]  rf_rp_addr;
   logic        rf_rp_rd;
   logic [3:0]  rf_rq_addr;
   logic        rf_rq_rd;
   logic        rf_rp_zero = 1'b0;
   logic [1:0]  alu_s;
   logic [3:0]  state_dbg;

   logic [15:0] prog [16];
   item_t       exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   assign i_data = (i_addr < 16'd16) ? prog[i_addr[3:0]] : 16'hF000;

   proc6_control_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_addr     (i_addr),
      .i_rd       (i_rd),
      .i_data     (i_data),
      .d_addr     (d_addr),
      .d_rd       (d_rd),
      .d_wr       (d_wr),
      .rf_w_data  (rf_w_data),
      .rf_s       (rf_s),
      .rf_w_addr  (rf_w_addr),
      .rf_w_wr    (rf_w_wr),
      .rf_rp_addr (rf_rp_addr),
      .rf_rp_rd   (rf_rp_rd),
      .rf_rq_addr (rf_rq_addr),
      .rf_rq_rd   (rf_rq_rd),
      .rf_rp_zero (rf_rp_zero),
      .alu_s      (alu_s),
      .state_dbg  (state_dbg)
   );

   task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.st  = state_dbg;
      o.ia  = i_addr;
      o.ird = i_rd;
      o.da  = d_addr;
      o.drd = d_rd;
      o.dwr = d_wr;
      o.wd  = rf_w_data;
      o.rs  = rf_s;
      o.wa  = rf_w_addr;
      o.wwr = rf_w_wr;
      o.pa  = rf_rp_addr;
      o.prd = rf_rp_rd;
      o.qa  = rf_rq_addr;
      o.qrd = rf_rq_rd;
      o.alu = alu_s;
      return o;
   endfunction

   // Expected outputs for one state, straight from the state table.
   function automatic obs_t snap(input logic [3:0] st, input logic [15:0] pc, input logic [15:0] ir);
      obs_t o;
      o    = '0;
      o.st = st;
      o.ia = pc;
      case (st)
         S_FETCH: o.ird = 1'b1;
         S_LOAD: begin
            o.da = ir[7:0]; o.drd = 1'b1; o.rs = 2'b01; o.wa = ir[11:8]; o.wwr = 1'b1;
         end
         S_STORE: begin
            o.da = ir[7:0]; o.dwr = 1'b1; o.pa = ir[11:8]; o.prd = 1'b1;
         end
         S_ADD, S_SUB: begin
            o.pa  = ir[7:4]; o.prd = 1'b1; o.qa = ir[3:0]; o.qrd = 1'b1;
            o.alu = (st == S_ADD) ? 2'b01 : 2'b10;
            o.wa  = ir[11:8]; o.wwr = 1'b1;
         end
         S_LOADC: begin
            o.rs = 2'b10; o.wd = ir[7:0]; o.wa = ir[11:8]; o.wwr = 1'b1;
         end
         S_JMPZ: begin
            o.pa = ir[11:8]; o.prd = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(input string name, input logic [3:0] st, input logic [15:0] pc,
                       input logic [15:0] ir);
      item_t it;
      it.tag = $sformatf("%s pc%h st%0d", name, pc, st);
      it.v   = snap(st, pc, ir);
      exp_q.push_back(it);
   endtask

   task automatic expect_instr(input string name, input logic [15:0] pc, input logic z,
                               output logic [15:0] npc);
      logic [15:0] ir;
      logic [15:0] pc1;
      ir  = (pc < 16'd16) ? prog[pc[3:0]] : 16'hF000;
      pc1 = pc + 16'd1;
      npc = pc1;
      push(name, S_FETCH, pc, 16'h0);
      push(name, S_DECODE, pc1, ir);
      case (ir[15:12])
         4'h0: push(name, S_LOAD, pc1, ir);
         4'h1: push(name, S_STORE, pc1, ir);
         4'h2: push(name, S_ADD, pc1, ir);
         4'h3: push(name, S_LOADC, pc1, ir);
         4'h4: push(name, S_SUB, pc1, ir);
         4'h5: begin
            push(name, S_JMPZ, pc1, ir);
            if (z) begin
               push(name, S_JMPZT, pc1, ir);
               npc = pc + {{8{ir[7]}}, ir[7:0]};
            end
         end
         default: ;
      endcase
   endtask

   task automatic drain();
      item_t it;
      while (exp_q.size() > 0) begin
         it = exp_q.pop_front();
         check_obs(it.tag, sample(), it.v);
         if (exp_q.size() > 0) @(negedge clk);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
   endtask

   task automatic run(input string name, input int n_instr, input logic z);
      logic [15:0] pc;
      rf_rp_zero = z;
      rst_n      = 1'b0;
      @(negedge clk);
      check_obs({name, " reset"}, sample(), '0);
      exp_q.delete();
      push(name, S_INIT, 16'h0, 16'h0);
      pc = 16'h0;
      for (int k = 0; k < n_instr; k++) expect_instr(name, pc, z, pc);
      rst_n = 1'b1;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      // LOADC, LOAD, STORE, ADD, then a taken backward JMPZ from 4 to 2
      clear_prog();
      prog[0] = 16'h3A05; prog[1] = 16'h0110; prog[2] = 16'h1220;
      prog[3] = 16'h2312; prog[4] = 16'h51FE;
      run("basic", 7, 1'b1);

      // SUB, a no-op and a not-taken JMPZ that falls through to 5
      clear_prog();
      prog[0] = 16'h4312; prog[1] = 16'hF123; prog[4] = 16'h51FE;
      run("fall", 6, 1'b0);

      // Offset 0 jumps to self
      clear_prog();
      prog[4] = 16'h5100;
      run("self", 7, 1'b1);

      // Backward branch from 0 to 0xFFFF, then the increment wraps back to 0
      clear_prog();
      prog[0] = 16'h50FF;
      run("wrap", 3, 1'b1);

      // Reset lands while the STORE strobe is high
      clear_prog();
      prog[0] = 16'h1220;
      run("rst", 1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_obs("rst async", sample(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      check_obs("rst init", sample(), snap(S_INIT, 16'h0, 16'h0));
      @(negedge clk);
      check_obs("rst refetch", sample(), snap(S_FETCH, 16'h0, 16'h0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/proc6_control_unit.md
Name: proc6_control_unit

Overview:
- FSM controller for the 6-instruction processor.
- Owns the PC and IR, fetches from program memory, decodes, and sequences one execute state per instruction.
- Drives the data-memory strobes and the register-file / ALU / write-mux controls of the datapath.
- Sits between program_memory, data_memory and the datapath (register file + ALU) inside the processor top.

Parameters:
PC_WIDTH, 16, width of PC and program-memory address
D_ADDR_WIDTH, 8, data-memory address width (instruction field [7:0])
RF_ADDR_WIDTH, 4, register-file address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
i_addr  out  PC_WIDTH  program-memory address (= PC)
i_rd  out  1  program-memory read enable
i_data  in  16  instruction word from program memory
d_addr  out  D_ADDR_WIDTH  data-memory address
d_rd  out  1  data-memory read enable
d_wr  out  1  data-memory write enable (memory writes on the clk edge)
rf_w_data  out  8  constant for LOADC (IR[7:0])
rf_s  out  2  RF write mux: 00 ALU, 01 data memory, 10 constant
rf_w_addr  out  RF_ADDR_WIDTH  RF write address
rf_w_wr  out  1  RF write enable
rf_rp_addr  out  RF_ADDR_WIDTH  RF read port P address
rf_rp_rd  out  1  read port P enable
rf_rq_addr  out  RF_ADDR_WIDTH  RF read port Q address
rf_rq_rd  out  1  read port Q enable
rf_rp_zero  in  1  datapath flag: RF[rp_addr] == 0
alu_s  out  2  ALU op: 00 pass A, 01 A+B, 10 A-B
state_dbg  out  4  current state encoding, for the bench

Behaviour:
Instruction format
- op = IR[15:12]; ra = IR[11:8]; d/c/offset = IR[7:0]; rb = IR[7:4]; rc = IR[3:0].
- Opcodes:
  - 0 LOAD: RF[ra] = D[d]
  - 1 STORE: D[d] = RF[ra]
  - 2 ADD: RF[ra] = RF[rb] + RF[rc]
  - 3 LOADC: RF[ra] = c
  - 4 SUB: RF[ra] = RF[rb] - RF[rc]
  - 5 JMPZ: if RF[ra] == 0, PC = PC + sext(offset)
  - 6..15: no-op

Reset
- rst_n low: asynchronously state = INIT, PC = 0, IR = 0.
- All enables/strobes 0; all addresses, rf_s and alu_s are 0.
- Reset is honoured in any state. A write strobe in progress is dropped with no partial update.

States (Moore; outputs decoded from state and IR; unlisted outputs 0)
- INIT: no strobes -> FETCH.
- FETCH: i_rd = 1, i_addr = PC. At the edge: IR <= i_data, PC <= PC + 1 -> DECODE.
- DECODE: no strobes -> state per op; 6..15 -> FETCH.
- LOAD: d_addr = d, d_rd = 1, rf_s = 01, rf_w_addr = ra, rf_w_wr = 1 -> FETCH.
- STORE: d_addr = d, d_wr = 1, rf_rp_addr = ra, rf_rp_rd = 1 -> FETCH.
- ADD / SUB:
  - rf_rp_addr = rb, rf_rq_addr = rc, both rd = 1.
  - alu_s = 01 (ADD) / 10 (SUB), rf_s = 00.
  - rf_w_addr = ra, rf_w_wr = 1 -> FETCH.
- LOADC: rf_s = 10, rf_w_data = c, rf_w_addr = ra, rf_w_wr = 1 -> FETCH.
- JMPZ: rf_rp_addr = ra, rf_rp_rd = 1. rf_rp_zero = 1 -> JMPZ_T; else -> FETCH.
- JMPZ_T: PC <= PC + sext(offset) - 1 (offset relative to the JMPZ address) -> FETCH.

Timing and arithmetic
- Latency: 3 cycles per instruction; taken JMPZ 4 cycles.
- PC arithmetic is modulo 2^PC_WIDTH. Increment wraps 0xFFFF -> 0; branch target wraps both directions.
- Offset 0 means jump-to-self, a legal infinite loop.
- rf_rp_zero is sampled only in JMPZ.
- d_wr is high for exactly one cycle per STORE. No strobe is ever asserted in INIT, DECODE or JMPZ_T.
- IR only changes in FETCH.

Test Plan:
- Reset, then release with program[0] = 0x3A05 -> INIT, FETCH, DECODE, LOADC sequence; in LOADC rf_w_wr = 1, rf_w_addr = A, rf_s = 10, rf_w_data = 05; PC = 1 after FETCH.
- 0x0110 then 0x1220 -> LOAD cycle: d_addr = 0x10, d_rd = 1, rf_s = 01, rf_w_addr = 1. STORE cycle: d_addr = 0x20, d_wr = 1 for one cycle, rf_rp_addr = 2.
- 0x2312 and 0x4312 -> rf_rp_addr = 1, rf_rq_addr = 2, rf_w_addr = 3; alu_s = 01 for ADD, 10 for SUB.
- JMPZ at address 4 with IR 0x51FE:
  - rf_rp_zero = 1 -> JMPZ_T, next fetch address 2.
  - rf_rp_zero = 0 -> next fetch address 5.
  - Offset 0x00 -> refetch address 4.
- Opcode 0xF -> DECODE goes straight to FETCH with no strobes. PC loaded to 0xFFFF via a backward branch from 0x0000 (offset 0xFF) -> next fetch at 0x0000 after increment wraps.
- Assert rst_n low mid-STORE (d_wr high) -> d_wr drops asynchronously, state INIT, PC = 0, IR = 0 within the same cycle.
